// File: rtl/mat_frame_ctrl.sv
// Double-buffered frame controller for the 8x16 LED matrix row scanner.
// The host fills the back bank over a valid/ready port and commits. Banks swap only
// on a frame tick, and the displayed front bank can be rotated left one column at a time.
module mat_frame_ctrl #(
    parameter int unsigned FRAME_TICKS = 40008,
    parameter int unsigned SCROLL_DIV  = 4
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [2:0]  wr_row,
    input  logic [15:0] wr_data,
    input  logic        commit,
    input  logic        scroll_en,
    output logic        busy,
    output logic        frame_sync,
    output logic [15:0] m0,
    output logic [15:0] m1,
    output logic [15:0] m2,
    output logic [15:0] m3,
    output logic [15:0] m4,
    output logic [15:0] m5,
    output logic [15:0] m6,
    output logic [15:0] m7
);

    localparam int unsigned ROWS = 8;
    localparam int unsigned COLS = 16;
    localparam int unsigned TW   = $clog2(FRAME_TICKS);
    localparam int unsigned DW   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SWAP = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [TW-1:0]     tick_cnt;
    logic [DW-1:0]     div_cnt;
    logic [3:0]        scroll_off;
    logic              front_sel;
    logic [COLS-1:0]   bank0 [ROWS];
    logic [COLS-1:0]   bank1 [ROWS];
    logic [COLS-1:0]   m_q   [ROWS];
    logic              tick_c;
    logic              wr_en_c;
    logic              swap_c;

    // Rotate a row left by the scroll offset.
    function automatic logic [COLS-1:0] rotl(input logic [COLS-1:0] d, input logic [3:0] s);
        logic [2*COLS-1:0] dd;
        dd = {d, d} << s;
        return dd[2*COLS-1:COLS];
    endfunction

    assign tick_c = (tick_cnt == TW'(FRAME_TICKS - 1));

    // Frame tick counter, free running.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick_c) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Next-state logic; swap is taken on the PEND->SWAP edge so frame_sync marks the new frame.
    always_comb begin
        state_d = state_q;
        wr_en_c = 1'b0;
        swap_c  = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en_c = wr_valid & wr_ready;
                if (commit) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (tick_c) begin
                    state_d = SWAP;
                    swap_c  = 1'b1;
                end
            end
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered status outputs that track it.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ready   <= 1'b0;
            busy       <= 1'b0;
            frame_sync <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ready   <= (state_d == IDLE);
            busy       <= (state_d == PEND);
            frame_sync <= (state_d == SWAP);
        end
    end

    // Bank select and scroll position; a swap restarts scrolling from column 0.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            front_sel  <= 1'b0;
            div_cnt    <= '0;
            scroll_off <= '0;
        end else if (swap_c) begin
            front_sel  <= ~front_sel;
            div_cnt    <= '0;
            scroll_off <= '0;
        end else if (tick_c && scroll_en && (state_q != SWAP)) begin
            if (div_cnt == DW'(SCROLL_DIV - 1)) begin
                div_cnt    <= '0;
                scroll_off <= scroll_off + 4'd1;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Host writes land in whichever bank is currently the back bank.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                bank0[r] <= '0;
                bank1[r] <= '0;
            end
        end else if (wr_en_c) begin
            if (front_sel) begin
                bank0[wr_row] <= wr_data;
            end else begin
                bank1[wr_row] <= wr_data;
            end
        end
    end

    // Registered, rotated view of the front bank for the scanner.
    always_ff @(posedge clock) begin
        for (int r = 0; r < ROWS; r++) begin
            if (!rst_n) begin
                m_q[r] <= '0;
            end else begin
                m_q[r] <= rotl(front_sel ? bank1[r] : bank0[r], scroll_off);
            end
        end
    end

    assign m0 = m_q[0];
    assign m1 = m_q[1];
    assign m2 = m_q[2];
    assign m3 = m_q[3];
    assign m4 = m_q[4];
    assign m5 = m_q[5];
    assign m6 = m_q[6];
    assign m7 = m_q[7];

endmodule

// File: tb/tb_mat_frame_ctrl.sv
// Bench for mat_frame_ctrl: directed scenarios followed by random traffic, checked
// cycle by cycle against a frame-level model plus a frame_sync scoreboard.
module tb_mat_frame_ctrl;

    localparam int unsigned FT = 10;
    localparam int unsigned SD = 2;

    typedef logic [7:0][15:0] frame_t;

    logic        clock;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_row;
    logic [15:0] wr_data;
    logic        commit;
    logic        scroll_en;
    logic        busy;
    logic        frame_sync;
    logic [15:0] m0, m1, m2, m3, m4, m5, m6, m7;
    logic [15:0] dm [8];

    mat_frame_ctrl #(.FRAME_TICKS(FT), .SCROLL_DIV(SD)) dut (
        .clock(clock), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_data(wr_data), .commit(commit), .scroll_en(scroll_en),
        .busy(busy), .frame_sync(frame_sync),
        .m0(m0), .m1(m1), .m2(m2), .m3(m3), .m4(m4), .m5(m5), .m6(m6), .m7(m7)
    );

    assign dm[0] = m0; assign dm[1] = m1; assign dm[2] = m2; assign dm[3] = m3;
    assign dm[4] = m4; assign dm[5] = m5; assign dm[6] = m6; assign dm[7] = m7;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    // Reference model: picture contents, commit bookkeeping, cycles since reset.
    logic [15:0] md_front [8];
    logic [15:0] md_back  [8];
    int          mode;        // 0 idle, 1 waiting for frame boundary, 2 swap cycle
    int          cyc;         // cycles since reset, frame boundary every FT
    int          sticks;      // scroll-enabled frame ticks since last swap/reset
    bit          e_ready, e_busy, e_fs;
    logic [15:0] e_m [8];
    frame_t      sbq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    function automatic logic [15:0] rot_ref(input logic [15:0] v, input int s);
        int unsigned x;
        x = 32'(v);
        if (s == 0) return v;
        return 16'(((x << s) | (x >> (16 - s))) & 32'hFFFF);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            md_front[r] = '0; md_back[r] = '0; e_m[r] = '0;
        end
        mode = 0; cyc = 0; sticks = 0;
        e_ready = 0; e_busy = 0; e_fs = 0;
    endtask

    task automatic model_edge(input bit rst, input bit v, input logic [2:0] row,
                              input logic [15:0] d, input bit c, input bit s);
        bit          tick;
        int          nxt;
        int          off;
        logic [15:0] t;
        frame_t      f;
        if (!rst) begin
            model_reset();
            return;
        end
        off = (sticks / SD) % 16;
        for (int r = 0; r < 8; r++) e_m[r] = rot_ref(md_front[r], off);
        tick = ((cyc % FT) == FT - 1);
        if (v && e_ready) md_back[row] = d;
        nxt = mode;
        if (mode == 0 && c) nxt = 1;
        else if (mode == 1 && tick) nxt = 2;
        else if (mode == 2) nxt = 0;
        if (mode == 1 && nxt == 2) begin
            for (int r = 0; r < 8; r++) begin
                t = md_front[r]; md_front[r] = md_back[r]; md_back[r] = t;
                f[r] = md_front[r];
            end
            sticks = 0;
            sbq.push_back(f);
        end else if (tick && s) begin
            sticks++;
        end
        cyc++;
        mode    = nxt;
        e_ready = (nxt == 0);
        e_busy  = (nxt == 1);
        e_fs    = (nxt == 2);
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input bit rst, input bit v, input logic [2:0] row,
                        input logic [15:0] d, input bit c, input bit s);
        rst_n = rst; wr_valid = v; wr_row = row; wr_data = d; commit = c; scroll_en = s;
        @(posedge clock);
        model_edge(rst, v, row, d, c, s);
        #1;
        chk("wr_ready", 32'(wr_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("frame_sync", 32'(frame_sync), 32'(e_fs));
        for (int r = 0; r < 8; r++) chk($sformatf("m%0d", r), 32'(dm[r]), 32'(e_m[r]));
        @(negedge clock);
    endtask

    task automatic idle(input int n, input bit s);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, s);
    endtask

    // Scoreboard monitor: each frame_sync must match a predicted swap; the frame shows next cycle.
    initial begin
        frame_t exp_f;
        forever begin
            @(negedge clock);
            if (frame_sync === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("sb_unexpected_frame_sync", 32'(1), 32'(0));
                end else begin
                    exp_f = sbq.pop_front();
                    @(negedge clock);
                    for (int r = 0; r < 8; r++)
                        chk($sformatf("sb_m%0d", r), 32'(dm[r]), 32'(exp_f[r]));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bit rnd_scroll;
        model_reset();
        rst_n = 1'b0; wr_valid = 1'b0; wr_row = '0; wr_data = '0; commit = 1'b0; scroll_en = 1'b0;
        @(negedge clock);

        // Reset held three cycles, then release.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        idle(2, 1'b0);

        // Walking-one picture, commit, wait for the swap.
        for (int r = 0; r < 8; r++) step(1'b1, 1'b1, 3'(r), 16'h0001 << r, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        idle(14, 1'b0);

        // Commit on the tick cycle; writes while pending must be ignored.
        for (int r = 0; r < 8; r++) step(1'b1, 1'b1, 3'(r), 16'h1111 * 16'(r + 1), 1'b0, 1'b0);
        guard = 0;
        while (!((cyc % FT) == FT - 1 && mode == 0) && guard < 40) begin
            idle(1, 1'b0); guard++;
        end
        chk("align_to_tick", 32'(guard < 40), 32'(1));
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd2, 16'hFFFF, 1'b0, 1'b0);
        idle(12, 1'b0);
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        idle(14, 1'b0);

        // Scroll a 16'h8001 row through a full wrap, then freeze.
        step(1'b1, 1'b1, 3'd0, 16'h8001, 1'b1, 1'b0);
        idle(14, 1'b0);
        idle(FT * 34, 1'b1);
        idle(30, 1'b0);

        // Write and commit together; a second commit while pending is ignored.
        step(1'b1, 1'b1, 3'd5, 16'hA5A5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        idle(14, 1'b0);

        // Reset while pending discards the swap.
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
        idle(3, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        idle(25, 1'b0);

        // Random traffic.
        rnd_scroll = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) rnd_scroll = ~rnd_scroll;
            step((mode == 2) ? 1'b1 : ($urandom_range(0, 199) != 0),
                 $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom),
                 $urandom_range(0, 7) == 0, rnd_scroll);
        end
        idle(15, 1'b0);
        chk("sb_queue_empty", 32'(sbq.size()), 32'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
